// File: rtl/icache_direct_mapped_pkg.sv
// ============================================================================
//  Module      : icache_direct_mapped_pkg
//  Description : Shared types and sizes for the direct-mapped instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_direct_mapped_pkg;

    localparam int ITAG_W      = 26;
    localparam int IIDX_W      = 4;
    localparam int IBYT_W      = 2;
    localparam int ICACHE_SETS = 2 ** IIDX_W;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        IC_IDLE = 1'b0,
        IC_MISS = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

`default_nettype wire

// File: rtl/icache_direct_mapped_if.sv
// ============================================================================
//  Module      : icache_direct_mapped_if
//  Description : Fetch-side and memory-side signals of the instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_direct_mapped_if;
    import icache_direct_mapped_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  flush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // slave: the cache itself; master: fetch stage plus memory controller
    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

`default_nettype wire

// File: rtl/icache_frame_array.sv
// ============================================================================
//  Module      : icache_frame_array
//  Description : Frame storage, async read / sync write; valid bits cleared by
//                reset (async) and flush (sync). Tag/data are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_frame_array
    import icache_direct_mapped_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              flush,
    input  wire logic [IIDX_W-1:0] rd_idx,
    output icache_frame_t          rd_frame,
    input  wire logic              wr_en,
    input  wire logic [IIDX_W-1:0] wr_idx,
    input  wire logic [ITAG_W-1:0] wr_tag,
    input  word_t                  wr_data
);

    logic [NSETS-1:0]  valid;
    logic [ITAG_W-1:0] tags  [NSETS];
    word_t             datas [NSETS];

    // flush beats a simultaneous fill so the filled frame stays invalid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            datas[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_frame       = '0;
        rd_frame.valid = valid[rd_idx];
        rd_frame.tag   = tags[rd_idx];
        rd_frame.data  = datas[rd_idx];
    end

endmodule

`default_nettype wire

// File: rtl/icache_direct_mapped.sv
// ============================================================================
//  Module      : icache_direct_mapped
//  Description : Direct-mapped 1-word-block icache: hit compare, miss FSM.
//                Define ICACHE_STATS_EN to add saturating hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct_mapped
    import icache_direct_mapped_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    icache_direct_mapped_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output word_t                 hit_count,
    output word_t                 miss_count
`endif
);

    if (NSETS != ICACHE_SETS) begin : g_nsets_check
        $error("icache_direct_mapped: NSETS must equal 2**IIDX_W");
    end

    icachef_t      fa;
    icache_state_t state;
    icache_state_t state_next;
    icache_frame_t rd_frame;
    logic [29:0]   miss_word;
    logic          hit;
    logic          fill;
    logic          take_miss;
    logic          iren;
    logic          unused_bytoff;

    assign fa            = bus.imemaddr;
    assign unused_bytoff = ^fa.bytoff;

    icache_frame_array #(
        .NSETS (NSETS)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (bus.flush),
        .rd_idx   (fa.idx),
        .rd_frame (rd_frame),
        .wr_en    (fill),
        .wr_idx   (miss_word[IIDX_W-1:0]),
        .wr_tag   (miss_word[29:IIDX_W]),
        .wr_data  (bus.iload)
    );

    assign hit          = bus.imemREN && (state == IC_IDLE) && rd_frame.valid
                          && (rd_frame.tag == fa.tag);
    assign bus.ihit     = hit;
    assign bus.imemload = hit ? rd_frame.data : '0;
    assign bus.iREN     = iren;
    assign bus.iaddr    = {miss_word, 2'b00};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IC_IDLE;
            miss_word <= '0;
        end else begin
            state <= state_next;
            if (take_miss) begin
                miss_word <= bus.imemaddr[31:2];
            end
        end
    end

    // The fill always targets the latched miss_word, so a fetch redirect
    // during IC_MISS is re-examined only once back in IC_IDLE.
    always_comb begin
        state_next = state;
        iren       = 1'b0;
        fill       = 1'b0;
        take_miss  = 1'b0;
        case (state)
            IC_IDLE: begin
                if (bus.imemREN && !hit && !bus.flush) begin
                    take_miss  = 1'b1;
                    state_next = IC_MISS;
                end
            end
            IC_MISS: begin
                iren = 1'b1;
                if (!bus.iwait) begin
                    fill       = 1'b1;
                    state_next = IC_IDLE;
                end
            end
            default: state_next = IC_IDLE;
        endcase
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (take_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
// ============================================================================
//  Module      : tb_icache_direct_mapped
//  Description : Scoreboard bench: fetch loads and memory addresses are queued
//                as expected when stimulus is driven, popped when produced.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_direct_mapped;
    import icache_direct_mapped_pkg::*;

    logic CLK;
    logic RST;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat      = 3;
    bit   mem_busy = 0;
    int   mem_cnt  = 0;

    word_t data_q[$];
    word_t miss_q[$];

`ifdef ICACHE_STATS_EN
    word_t hit_count;
    word_t miss_count;
`endif

    icache_direct_mapped_if ibus ();

    icache_direct_mapped #(
        .NSETS (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (ibus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic word_t mem_word(input word_t a);
        return a ^ 32'h2001_0045;
    endfunction

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Memory controller model: 'lat' busy cycles, then one data cycle.
    initial begin
        ibus.iwait = 1'b1;
        ibus.iload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                mem_busy   = 0;
                mem_cnt    = 0;
                ibus.iwait = 1'b1;
            end else if (ibus.iREN) begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_cnt  = 0;
                    if (miss_q.size() == 0) check_eq("unexpected_miss", miss_q.size(), 1);
                    else check_eq("mem_iaddr", ibus.iaddr, miss_q.pop_front());
                end
                if (mem_cnt >= lat) begin
                    ibus.iwait = 1'b0;
                    ibus.iload = mem_word(ibus.iaddr);
                end else begin
                    ibus.iwait = 1'b1;
                    mem_cnt++;
                end
            end else begin
                mem_busy   = 0;
                ibus.iwait = 1'b1;
                ibus.iload = '0;
            end
        end
    end

    // Waits (bounded) for ihit, then checks the load against the scoreboard.
    task automatic wait_hit(output int n);
        bit got;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge CLK);
            if (ibus.ihit) got = 1;
            else begin
                n++;
                @(posedge CLK);
                #1;
                ibus.flush = 1'b0;
            end
        end
        if (!got) begin
            check_eq("hit_timeout", ibus.ihit, 1);
            if (data_q.size() != 0) void'(data_q.pop_front());
        end else begin
            check_eq("imemload", ibus.imemload, data_q.pop_front());
            check_eq("iREN_on_hit", ibus.iREN, 0);
        end
    endtask

    task automatic fetch(input word_t a, input bit miss, input bit pre_flush);
        int n;
        int exp_n;
        ibus.imemREN  = 1'b1;
        ibus.imemaddr = a;
        ibus.flush    = pre_flush;
        data_q.push_back(mem_word({a[31:2], 2'b00}));
        if (miss) miss_q.push_back({a[31:2], 2'b00});
        exp_n = miss ? (pre_flush ? lat + 3 : lat + 2) : 0;
        wait_hit(n);
        check_eq("latency", n, exp_n);
        @(posedge CLK);
        #1;
        ibus.imemREN = 1'b0;
        ibus.flush   = 1'b0;
    endtask

    initial begin
        int n;
        RST           = 1'b1;
        ibus.imemREN  = 1'b1;
        ibus.imemaddr = 32'h40;
        ibus.flush    = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_ihit", ibus.ihit, 0);
        check_eq("rst_imemload", ibus.imemload, 0);
        check_eq("rst_iREN", ibus.iREN, 0);
        check_eq("rst_iaddr", ibus.iaddr, 0);
        ibus.imemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
`ifdef ICACHE_STATS_EN
        check_eq("rst_hit_count", hit_count, 0);
        check_eq("rst_miss_count", miss_count, 0);
`endif

        // cold miss, then hits (byte offset ignored)
        lat = 3;
        fetch(32'h40, 1, 0);
`ifdef ICACHE_STATS_EN
        check_eq("miss_count_1", miss_count, 1);
`endif
        fetch(32'h40, 0, 0);
        fetch(32'h42, 0, 0);
        ibus.imemREN  = 1'b1;
        ibus.imemaddr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            data_q.push_back(mem_word(32'h40));
            @(negedge CLK);
            check_eq("hold_ihit", ibus.ihit, 1);
            check_eq("hold_load", ibus.imemload, data_q.pop_front());
            @(posedge CLK);
            #1;
        end
        ibus.imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
        check_eq("hit_count_6", hit_count, 6);
`endif

        // conflict eviction on idx 0, neighbour index untouched
        fetch(32'h80, 1, 0);
        fetch(32'h40, 1, 0);
        fetch(32'h44, 1, 0);
        fetch(32'h40, 0, 0);

        // redirect mid-miss
        ibus.imemREN  = 1'b1;
        ibus.imemaddr = 32'h100;
        miss_q.push_back(32'h100);
        miss_q.push_back(32'h104);
        data_q.push_back(mem_word(32'h104));
        @(posedge CLK);
        #1;
        ibus.imemaddr = 32'h104;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_eq("redir_iREN", ibus.iREN, 1);
            check_eq("redir_iaddr", ibus.iaddr, 32'h100);
            @(posedge CLK);
            #1;
        end
        wait_hit(n);
        @(posedge CLK);
        #1;
        ibus.imemREN = 1'b0;
        fetch(32'h100, 0, 0);
        fetch(32'h104, 0, 0);

        // flush between fetches
        fetch(32'h40, 1, 0);
        ibus.flush = 1'b1;
        @(posedge CLK);
        #1;
        ibus.flush = 1'b0;
        fetch(32'h40, 1, 0);
        fetch(32'h104, 1, 0);

        // flush coinciding with the fill: frame must miss again
        lat           = 0;
        ibus.imemREN  = 1'b1;
        ibus.imemaddr = 32'h48;
        miss_q.push_back(32'h48);
        miss_q.push_back(32'h48);
        data_q.push_back(mem_word(32'h48));
        @(posedge CLK);
        #1;
        ibus.flush = 1'b1;
        @(negedge CLK);
        check_eq("fill_flush_iREN", ibus.iREN, 1);
        @(posedge CLK);
        #1;
        ibus.flush = 1'b0;
        wait_hit(n);
        check_eq("fill_flush_latency", n, 2);
        @(posedge CLK);
        #1;
        ibus.imemREN = 1'b0;

        // flush and miss in the same cycle: miss deferred one cycle
        fetch(32'h4C, 1, 1);

        // async reset mid-miss
        lat = 2;
        fetch(32'h40, 1, 0);
        fetch(32'h40, 0, 0);
        ibus.imemREN  = 1'b1;
        ibus.imemaddr = 32'h208;
        miss_q.push_back(32'h208);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check_eq("arst_iREN", ibus.iREN, 0);
        check_eq("arst_ihit", ibus.ihit, 0);
        check_eq("arst_imemload", ibus.imemload, 0);
        check_eq("arst_iaddr", ibus.iaddr, 0);
        ibus.imemREN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
`ifdef ICACHE_STATS_EN
        check_eq("arst_hit_count", hit_count, 0);
`endif
        @(posedge CLK);
        #1;
        fetch(32'h40, 1, 0);
        fetch(32'h40, 0, 0);

        repeat (2) @(posedge CLK);
        check_eq("miss_q_empty", miss_q.size(), 0);
        check_eq("data_q_empty", data_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
